// File: rtl/pattern_stream_gen_pkg.sv
// Shared types and helpers for the packet pattern stream source.
// Mode/state encodings, header length, LFSR step.
package pattern_stream_gen_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR = 2'd0,
    MODE_INC  = 2'd1,
    MODE_FIX  = 2'd2,
    MODE_RSV  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [15:0] HDR_LEN   = 16'd4;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Fibonacci step, taps at bits 31, 21, 1, 0.
  function automatic logic [31:0] lfsr32_next(
    input logic [31:0] s
  );
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

  // The reserved mode code behaves as LFSR.
  function automatic mode_e norm_mode(
    input logic [1:0] m
  );
    return (m == 2'd3) ? MODE_LFSR : mode_e'(m);
  endfunction

  // Every packet carries at least the header.
  function automatic logic [15:0] clamp_len(
    input logic [15:0] l
  );
    return (l < HDR_LEN) ? HDR_LEN : l;
  endfunction

endpackage

// File: rtl/pattern_stream_gen_beat_byte_mux.sv
// Combinational beat builder: byte index, mode, counter,
// LFSR and pattern in; MSB-first data and keep lanes out.
module beat_byte_mux
  import pattern_stream_gen_pkg::*;
#(
  parameter int DATA_BYTES = 1
) (
  input  logic [15:0]             idx,
  input  logic [15:0]             len,
  input  logic [1:0]              mode,
  input  logic [31:0]             cnt,
  input  logic [31:0]             lfsr,
  input  logic [31:0]             pat,
  output logic [8*DATA_BYTES-1:0] data,
  output logic [DATA_BYTES-1:0]   keep
);

  // Lane 0 is the most significant byte of a word.
  function automatic logic [7:0] pick(
    input logic [31:0] w,
    input logic [1:0]  ln
  );
    return 8'(w >> {~ln, 3'b000});
  endfunction

  // Header and payload both start word aligned, so the
  // lane within a word is always the low two index bits.
  function automatic logic [7:0] byte_at(
    input logic [16:0] j
  );
    logic       hdr;
    logic [7:0] b;
    hdr = j < 17'(HDR_LEN);
    b   = '0;
    unique case (1'b1)
      hdr:
        b = pick(cnt, j[1:0]);
      (!hdr && mode == MODE_INC):
        b = j[7:0] - 8'd4;
      (!hdr && mode == MODE_FIX):
        b = pick(pat, j[1:0]);
      default:
        b = pick(lfsr, j[1:0]);
    endcase
    return b;
  endfunction

  always_comb begin
    data = '0;
    keep = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if ({1'b0, idx} + 17'(k) < {1'b0, len}) begin
        keep[DATA_BYTES-1-k] = 1'b1;
        data[8*(DATA_BYTES-1-k) +: 8] =
          byte_at({1'b0, idx} + 17'(k));
      end
    end
  end

endmodule

// File: rtl/pattern_stream_gen.sv
// Test-pattern packet source: 4-byte counter header then
// LFSR / incrementing / fixed payload on a valid/ready stream.
// Ports: i_clk, i_rst_n (async low), i_start, i_len, i_mode,
//   i_seed_load, i_seed_data, i_abort, i_ready in;
//   o_valid, o_data, o_keep, o_last, o_busy, o_pkt_count out.
module pattern_stream_gen
  import pattern_stream_gen_pkg::*;
#(
  parameter int          DATA_BYTES   = 1,
  parameter logic [31:0] SEED_DEFAULT = 32'hFFFF_FFFF,
  parameter logic [31:0] CNT_INIT     = 32'h0123_4567
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [15:0]             i_len,
  input  logic [1:0]              i_mode,
  input  logic                    i_seed_load,
  input  logic [31:0]             i_seed_data,
  input  logic                    i_abort,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [8*DATA_BYTES-1:0] o_data,
  output logic [DATA_BYTES-1:0]   o_keep,
  output logic                    o_last,
  output logic                    o_busy,
  output logic [31:0]             o_pkt_count
);

  localparam logic [16:0] STEP = 17'(DATA_BYTES);

  state_e      state_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  mode_e       mode_q;
  logic [31:0] pat_q;
  logic [31:0] cnt_q;
  logic [31:0] lfsr_q;

  logic        xfer;
  logic [16:0] idx_nxt;
  logic        beat_last;
  logic        word_end;
  logic        lfsr_adv;
  logic        pkt_end;

  logic [8*DATA_BYTES-1:0] mux_data;
  logic [DATA_BYTES-1:0]   mux_keep;

  assign xfer      = o_valid & i_ready;
  assign idx_nxt   = {1'b0, idx_q} + STEP;
  assign beat_last = idx_nxt >= {1'b0, len_q};
  assign word_end  = idx_nxt[1:0] == 2'b00;

  // One LFSR step per payload word, taken when the beat
  // holding its final byte (or the packet's final byte) moves.
  assign lfsr_adv = xfer
                 && mode_q == MODE_LFSR
                 && idx_q >= HDR_LEN
                 && (word_end || beat_last);

  assign pkt_end = i_abort || (xfer && beat_last);

  beat_byte_mux #(
    .DATA_BYTES (DATA_BYTES)
  ) u_mux (
    .idx  (idx_q),
    .len  (len_q),
    .mode (mode_q),
    .cnt  (cnt_q),
    .lfsr (lfsr_q),
    .pat  (pat_q),
    .data (mux_data),
    .keep (mux_keep)
  );

  assign o_data      = o_valid ? mux_data : '0;
  assign o_keep      = o_valid ? mux_keep : '0;
  assign o_last      = o_valid & beat_last;
  assign o_pkt_count = cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      len_q   <= HDR_LEN;
      idx_q   <= '0;
      mode_q  <= MODE_LFSR;
      pat_q   <= '0;
      cnt_q   <= CNT_INIT;
      lfsr_q  <= SEED_DEFAULT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_seed_load) begin
            lfsr_q <= (i_seed_data == '0)
                    ? SEED_DEFAULT : i_seed_data;
            cnt_q  <= CNT_INIT;
          end else if (i_start) begin
            len_q   <= clamp_len(i_len);
            mode_q  <= norm_mode(i_mode);
            pat_q   <= i_seed_data;
            idx_q   <= '0;
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (lfsr_adv) begin
            lfsr_q <= lfsr32_next(lfsr_q);
          end
          if (xfer) begin
            idx_q <= idx_nxt[15:0];
          end
          if (pkt_end) begin
            cnt_q   <= cnt_q + 32'd1;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Bench: three widths (1/2/4 bytes) driven in lockstep and
// compared every cycle against a byte-level packet model.
module tb_pattern_stream_gen;

  localparam logic [31:0] SEED_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] CNT0     = 32'h0123_4567;

  localparam logic [7:0] EXP_T1 [12] = '{
    8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'h00,
    8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03};
  localparam logic [31:0] EXP_T1W [3] = '{
    32'h0123_4567, 32'h0000_0001, 32'h0000_0003};
  localparam logic [15:0] EXP_T3 [5] = '{
    16'h0123, 16'h4567, 16'hA5C3, 16'h1E0F, 16'hA5C3};
  localparam logic [7:0] EXP_T4 [8] = '{
    8'h01, 8'h23, 8'h45, 8'h68, 8'hFF, 8'hFF,
    8'hFF, 8'hFF};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] len = '0;
  logic [1:0]  mode = '0;
  logic [31:0] seed = '0;

  logic [7:0]  d0;
  logic [15:0] d1;
  logic [31:0] d2;
  logic [0:0]  k0;
  logic [1:0]  k1;
  logic [3:0]  k2;
  logic [2:0]  vld, lst, bsy;
  logic [31:0] pc0, pc1, pc2;

  pattern_stream_gen #(
    .DATA_BYTES(1), .SEED_DEFAULT(SEED_DEF), .CNT_INIT(CNT0)
  ) u_db1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_len(len), .i_mode(mode), .i_seed_load(seed_load),
    .i_seed_data(seed), .i_abort(abort), .i_ready(ready),
    .o_valid(vld[0]), .o_data(d0), .o_keep(k0),
    .o_last(lst[0]), .o_busy(bsy[0]), .o_pkt_count(pc0)
  );

  pattern_stream_gen #(
    .DATA_BYTES(2), .SEED_DEFAULT(SEED_DEF), .CNT_INIT(CNT0)
  ) u_db2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_len(len), .i_mode(mode), .i_seed_load(seed_load),
    .i_seed_data(seed), .i_abort(abort), .i_ready(ready),
    .o_valid(vld[1]), .o_data(d1), .o_keep(k1),
    .o_last(lst[1]), .o_busy(bsy[1]), .o_pkt_count(pc1)
  );

  pattern_stream_gen #(
    .DATA_BYTES(4), .SEED_DEFAULT(SEED_DEF), .CNT_INIT(CNT0)
  ) u_db4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_len(len), .i_mode(mode), .i_seed_load(seed_load),
    .i_seed_data(seed), .i_abort(abort), .i_ready(ready),
    .o_valid(vld[2]), .o_data(d2), .o_keep(k2),
    .o_last(lst[2]), .o_busy(bsy[2]), .o_pkt_count(pc2)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model, one slot per width.
  bit          m_act  [3];
  int          m_sent [3];
  int          m_len  [3];
  int          m_mode [3];
  logic [31:0] m_pat  [3];
  logic [31:0] m_cnt  [3];
  logic [31:0] m_lfsr [3];

  logic [7:0]  cap0 [$];
  logic [15:0] cap1 [$];
  logic [31:0] cap2 [$];
  logic [3:0]  capk2 [$];

  function automatic logic [31:0] lfsr_pow(
    input logic [31:0] s, input int n
  );
    logic [31:0] r = s;
    for (int t = 0; t < n; t++)
      r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    return r;
  endfunction

  // Payload words whose LFSR step has been taken once n
  // bytes of a len-byte packet have left.
  function automatic int adv_count(input int n, input int l);
    if (n <= 4) return 0;
    if (n >= l) return (l - 4 + 3) / 4;
    return (n - 4) / 4;
  endfunction

  function automatic logic [7:0] ref_byte(input int i, input int j);
    logic [31:0] w;
    int p;
    if (j < 4) return 8'(m_cnt[i] >> (8 * (3 - j)));
    p = j - 4;
    if (m_mode[i] == 1) return 8'(p % 256);
    w = (m_mode[i] == 2) ? m_pat[i] : lfsr_pow(m_lfsr[i], p / 4);
    return 8'(w >> (8 * (3 - p % 4)));
  endfunction

  function automatic logic [31:0] obs_data(input int i);
    if (i == 0) return {24'h0, d0};
    if (i == 1) return {16'h0, d1};
    return d2;
  endfunction

  function automatic logic [3:0] obs_keep(input int i);
    if (i == 0) return {3'b0, k0};
    if (i == 1) return {2'b0, k1};
    return k2;
  endfunction

  function automatic logic [31:0] obs_pc(input int i);
    if (i == 0) return pc0;
    if (i == 1) return pc1;
    return pc2;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      automatic int db = 1 << i;
      automatic logic [31:0] ed = '0;
      automatic logic [3:0] ek = '0;
      automatic logic el = 1'b0;
      automatic bit done = 1'b0;
      if (!rst_n) begin
        m_act[i]  = 1'b0;
        m_sent[i] = 0;
        m_cnt[i]  = CNT0;
        m_lfsr[i] = SEED_DEF;
      end
      if (m_act[i]) begin
        for (int k = 0; k < db; k++) begin
          if (m_sent[i] + k < m_len[i]) begin
            ek[db-1-k] = 1'b1;
            ed[8*(db-1-k) +: 8] = ref_byte(i, m_sent[i] + k);
          end
        end
        el = (m_sent[i] + db >= m_len[i]);
      end
      chk($sformatf("valid%0d", i), 32'(vld[i]), 32'(m_act[i]));
      chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_act[i]));
      chk($sformatf("data%0d", i), obs_data(i), ed);
      chk($sformatf("keep%0d", i), 32'(obs_keep(i)), 32'(ek));
      chk($sformatf("last%0d", i), 32'(lst[i]), 32'(el));
      chk($sformatf("count%0d", i), obs_pc(i), m_cnt[i]);
      if (rst_n) begin
        if (m_act[i]) begin
          if (ready) begin
            if (i == 0) cap0.push_back(d0);
            if (i == 1) cap1.push_back(d1);
            if (i == 2) begin
              cap2.push_back(d2);
              capk2.push_back(k2);
            end
            m_sent[i] += db;
            done = m_sent[i] >= m_len[i];
          end
          if (done || abort) begin
            m_act[i] = 1'b0;
            m_cnt[i] = m_cnt[i] + 32'd1;
            if (m_mode[i] == 0)
              m_lfsr[i] = lfsr_pow(m_lfsr[i],
                adv_count(m_sent[i], m_len[i]));
          end
        end else if (seed_load) begin
          m_lfsr[i] = (seed == '0) ? SEED_DEF : seed;
          m_cnt[i]  = CNT0;
        end else if (start) begin
          m_act[i]  = 1'b1;
          m_sent[i] = 0;
          m_len[i]  = (len < 16'd4) ? 4 : int'(len);
          m_mode[i] = (mode == 2'd3) ? 0 : int'(mode);
          m_pat[i]  = seed;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_caps;
    cap0.delete();
    cap1.delete();
    cap2.delete();
    capk2.delete();
  endtask

  task automatic seed_pulse(input logic [31:0] v);
    seed = v;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic run_pkt(
    input int l, input int md, input logic [31:0] pat,
    input int stall, input int abort_pct, input bit noise
  );
    bit fin = 1'b0;
    len   = 16'(l);
    mode  = 2'(md);
    seed  = pat;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      ready = ($urandom_range(99) >= stall);
      abort = (abort_pct > 0) &&
              ($urandom_range(99) < abort_pct);
      seed_load = noise && ($urandom_range(15) == 0);
      if (seed_load)
        seed = ($urandom_range(3) == 0) ? '0 : $urandom;
      tick();
      if (bsy == 3'b000) fin = 1'b1;
    end
    if (!fin) chk("pkt_timeout", 32'(bsy), 32'd0);
    ready = 1'b0;
    abort = 1'b0;
    seed_load = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_d4", d2, 32'd0);
    chk("rst_cnt", pc2, CNT0);
    rst_n = 1'b1;
    tick();

    // LFSR seeded to 1, 12-byte packet
    seed_pulse(32'h1);
    clear_caps();
    run_pkt(12, 0, 32'h0, 0, 0, 1'b0);
    chk("t1_n", 32'(cap0.size()), 32'd12);
    for (int k = 0; k < 12 && k < cap0.size(); k++)
      chk($sformatf("t1_b%0d", k), 32'(cap0[k]), 32'(EXP_T1[k]));
    for (int k = 0; k < 3 && k < cap2.size(); k++)
      chk($sformatf("t1_w%0d", k), cap2[k], EXP_T1W[k]);
    tick();
    chk("t1_cnt", pc0, 32'h0123_4568);

    // Incrementing payload, partial last beat
    do_reset();
    clear_caps();
    run_pkt(6, 1, 32'h0, 0, 0, 1'b0);
    chk("t2_n", 32'(cap2.size()), 32'd2);
    if (cap2.size() == 2) begin
      chk("t2_w0", cap2[0], 32'h0123_4567);
      chk("t2_k0", 32'(capk2[0]), 32'hF);
      chk("t2_w1", cap2[1], 32'h0001_0000);
      chk("t2_k1", 32'(capk2[1]), 32'hC);
    end

    // Fixed word with random back-pressure
    do_reset();
    clear_caps();
    run_pkt(10, 2, 32'hA5C3_1E0F, 50, 0, 1'b0);
    chk("t3_n", 32'(cap1.size()), 32'd5);
    for (int k = 0; k < 5 && k < cap1.size(); k++)
      chk($sformatf("t3_h%0d", k), 32'(cap1[k]), 32'(EXP_T3[k]));

    // Zero seed, header-only packet, then LFSR payload
    do_reset();
    seed = 32'h1234_5678;
    seed_load = 1'b1;
    start = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    chk("prio_idle", 32'(bsy), 32'd0);
    seed_pulse(32'h0);
    clear_caps();
    run_pkt(2, 0, 32'h0, 0, 0, 1'b0);
    run_pkt(8, 0, 32'h0, 0, 0, 1'b1);
    chk("t4_n", 32'(cap0.size()), 32'd12);
    for (int k = 0; k < 8 && k + 4 < cap0.size(); k++)
      chk($sformatf("t4_b%0d", k), 32'(cap0[k+4]), 32'(EXP_T4[k]));

    // Abort after six bytes
    do_reset();
    clear_caps();
    len = 16'd20;
    mode = 2'd1;
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_n", 32'(cap0.size()), 32'd6);
    chk("t5_busy", 32'(bsy), 32'd0);
    chk("t5_cnt", pc0, 32'h0123_4568);
    clear_caps();
    run_pkt(4, 1, 32'h0, 0, 0, 1'b0);
    chk("t5_hdr", {cap0.size() > 3 ? cap0[0] : 8'h0,
                   cap0.size() > 3 ? cap0[1] : 8'h0,
                   cap0.size() > 3 ? cap0[2] : 8'h0,
                   cap0.size() > 3 ? cap0[3] : 8'h0},
        32'h0123_4568);

    // Reset mid-packet, with an ignored start in RUN
    len = 16'd30;
    mode = 2'd0;
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(vld), 32'd0);
    chk("t6_last", 32'(lst), 32'd0);
    chk("t6_data", d2 | {16'h0, d1} | {24'h0, d0}, 32'd0);
    chk("t6_keep", 32'({k2, k1, k0}), 32'd0);
    chk("t6_cnt", pc1, CNT0);
    tick();
    rst_n = 1'b1;
    ready = 1'b0;
    tick();

    // Randomised packets
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(3) == 0)
        seed_pulse(($urandom_range(3) == 0) ? '0 : $urandom);
      run_pkt($urandom_range(0, 40), $urandom_range(0, 3),
              $urandom, $urandom_range(0, 60),
              ($urandom_range(3) == 0) ? 3 : 0, 1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
